// File: rtl/minimig_sram_bridge_fsm_if.sv
// Chipset-side request and memory-side pin bundle for the SRAM bridge.
// Handshake: a request is taken only on a Q1 clock (c1 & !c3) while busy=0,
// and only if some bank bit and some rd/write enable are set. It is latched
// on that edge and later input changes are ignored. Requests seen while busy=1
// are dropped, not queued. Completion is a single-clock ready pulse, and
// data_out is valid in the same clock as ready.
interface minimig_sram_bridge_fsm_if #(
  parameter int DW = 16,
  parameter int AW = 22
) ();
  logic          c1;
  logic          c3;
  logic [7:0]    bank;
  logic [23:1]   address_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_in2;
  logic [DW-1:0] data_out;
  logic          rd;
  logic          hwr;
  logic          lwr;
  logic          hwr2;
  logic          lwr2;
  logic          ready;
  logic          busy;
  logic          _bhe;
  logic          _ble;
  logic          _we;
  logic          _oe;
  logic [AW:1]   address;
  logic [DW-1:0] data;
  logic          data_oe;
  logic [DW-1:0] ramdata_in;

  modport slave (
    input  c1, c3, bank, address_in, data_in, data_in2,
    input  rd, hwr, lwr, hwr2, lwr2, ramdata_in,
    output data_out, ready, busy, _bhe, _ble, _we, _oe,
    output address, data, data_oe
  );

  modport master (
    output c1, c3, bank, address_in, data_in, data_in2,
    output rd, hwr, lwr, hwr2, lwr2, ramdata_in,
    input  data_out, ready, busy, _bhe, _ble, _we, _oe,
    input  address, data, data_oe
  );
endinterface

// File: rtl/minimig_sram_bridge_fsm.sv
// Registered chipset-to-SRAM bridge: latches a bus cycle at Q1 and runs
// setup/strobe/hold timing toward asynchronous SRAM with parametrised waits.
module minimig_sram_bridge_fsm #(
  parameter int DW      = 16,
  parameter int AW      = 22,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1,
  parameter int BURST2  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  minimig_sram_bridge_fsm_if.slave bus,
  output logic [1:0]               state_dbg_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = (MAXW < 2) ? 1 : $clog2(MAXW + 1);
  localparam logic [CW-1:0] RD_CNT = CW'(RD_WAIT);
  localparam logic [CW-1:0] WR_CNT = CW'(WR_WAIT);
  localparam logic          B2_EN  = (BURST2 != 0);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_rd_q, is_rd_d;
  logic          pend_q, pend_d;
  logic          be_h_q, be_h_d;
  logic          be_l_q, be_l_d;
  logic          be2_h_q, be2_h_d;
  logic          be2_l_q, be2_l_d;
  logic [DW-1:0] data2_q, data2_d;
  logic [AW:1]   addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          data_oe_q, data_oe_d;
  logic          we_n_q, we_n_d;
  logic          oe_n_q, oe_n_d;
  logic          bhe_n_q, bhe_n_d;
  logic          ble_n_q, ble_n_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] dout_q, dout_d;

  logic          q1;
  logic          req_w0;
  logic          req_w1;
  logic          start;
  logic [AW:1]   mapped_addr;
  logic          unused_addr_msb;

  assign q1              = bus.c1 & ~bus.c3;
  assign req_w0          = bus.hwr | bus.lwr;
  assign req_w1          = B2_EN & (bus.hwr2 | bus.lwr2);
  assign start           = (state_q == S_IDLE) & q1 & (|bus.bank) & (bus.rd | req_w0 | req_w1);
  assign unused_addr_msb = bus.address_in[23];

  // Chip-RAM / slow-RAM / ROM banks fold onto the upper SRAM address lines.
  always_comb begin
    mapped_addr        = '0;
    mapped_addr[17:1]  = bus.address_in[17:1];
    if (bus.bank[7] | bus.bank[6]) begin
      mapped_addr[22:18] = {3'b111, bus.bank[7], bus.address_in[18]};
    end else if (bus.bank[5]) begin
      mapped_addr[22:18] = {2'b00, bus.bank[3] | bus.bank[2], bus.bank[3] | bus.bank[1],
                            bus.address_in[18]};
    end else begin
      mapped_addr[22:18] = bus.address_in[22:18];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rd_d   = is_rd_q;
    pend_d    = pend_q;
    be_h_d    = be_h_q;
    be_l_d    = be_l_q;
    be2_h_d   = be2_h_q;
    be2_l_d   = be2_l_q;
    data2_d   = data2_q;
    addr_d    = addr_q;
    data_d    = data_q;
    data_oe_d = data_oe_q;
    we_n_d    = we_n_q;
    oe_n_d    = oe_n_q;
    bhe_n_d   = bhe_n_q;
    ble_n_d   = ble_n_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    dout_d    = dout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          busy_d  = 1'b1;
          is_rd_d = bus.rd;
          data2_d = bus.data_in2;
          be2_h_d = bus.hwr2;
          be2_l_d = bus.lwr2;
          if (bus.rd) begin
            // A read beats any simultaneous write enables, which are dropped.
            addr_d    = mapped_addr;
            data_d    = bus.data_in;
            be_h_d    = 1'b1;
            be_l_d    = 1'b1;
            pend_d    = 1'b0;
            data_oe_d = 1'b0;
          end else if (req_w0) begin
            addr_d    = mapped_addr;
            data_d    = bus.data_in;
            be_h_d    = bus.hwr;
            be_l_d    = bus.lwr;
            pend_d    = req_w1;
            data_oe_d = 1'b1;
          end else begin
            // Word 0 has no byte enables: run only the second word.
            addr_d    = mapped_addr + AW'(1);
            data_d    = bus.data_in2;
            be_h_d    = bus.hwr2;
            be_l_d    = bus.lwr2;
            pend_d    = 1'b0;
            data_oe_d = 1'b1;
          end
        end
      end

      S_SETUP: begin
        state_d = S_STROBE;
        if (is_rd_q) begin
          cnt_d   = RD_CNT;
          oe_n_d  = 1'b0;
          bhe_n_d = 1'b0;
          ble_n_d = 1'b0;
        end else begin
          cnt_d   = WR_CNT;
          we_n_d  = 1'b0;
          bhe_n_d = ~be_h_q;
          ble_n_d = ~be_l_q;
        end
      end

      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          bhe_n_d = 1'b1;
          ble_n_d = 1'b1;
          ready_d = ~pend_q;
          if (is_rd_q) begin
            dout_d = bus.ramdata_in;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_HOLD: begin
        ready_d = 1'b0;
        if (pend_q) begin
          state_d = S_SETUP;
          addr_d  = addr_q + AW'(1);
          data_d  = data2_q;
          be_h_d  = be2_h_q;
          be_l_d  = be2_l_q;
          pend_d  = 1'b0;
        end else begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          data_oe_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_rd_q   <= 1'b0;
      pend_q    <= 1'b0;
      be_h_q    <= 1'b0;
      be_l_q    <= 1'b0;
      be2_h_q   <= 1'b0;
      be2_l_q   <= 1'b0;
      data2_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      data_oe_q <= 1'b0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      bhe_n_q   <= 1'b1;
      ble_n_q   <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_rd_q   <= is_rd_d;
      pend_q    <= pend_d;
      be_h_q    <= be_h_d;
      be_l_q    <= be_l_d;
      be2_h_q   <= be2_h_d;
      be2_l_q   <= be2_l_d;
      data2_q   <= data2_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      data_oe_q <= data_oe_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      bhe_n_q   <= bhe_n_d;
      ble_n_q   <= ble_n_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      dout_q    <= dout_d;
    end
  end

  assign bus.data_out = dout_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus._bhe     = bhe_n_q;
  assign bus._ble     = ble_n_q;
  assign bus._we      = we_n_q;
  assign bus._oe      = oe_n_q;
  assign bus.address  = addr_q;
  assign bus.data     = data_q;
  assign bus.data_oe  = data_oe_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_minimig_sram_bridge_fsm.sv
// Bench for minimig_sram_bridge_fsm: directed vector table, corner sequences
// and random cycles checked clock by clock against a phase-list model.
module tb_minimig_sram_bridge_fsm;
  localparam int DW      = 16;
  localparam int AW      = 22;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 1;
  localparam int BURST2  = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  minimig_sram_bridge_fsm_if #(.DW(DW), .AW(AW)) bus ();

  minimig_sram_bridge_fsm #(
    .DW(DW), .AW(AW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .BURST2(BURST2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          busy;
    logic          ready;
    logic          we_n;
    logic          oe_n;
    logic          bhe_n;
    logic          ble_n;
    logic          data_oe;
    logic [AW:1]   address;
    logic [DW-1:0] data;
    logic [DW-1:0] data_out;
  } pin_t;

  typedef struct {
    logic [7:0]    bank;
    logic [23:1]   addr;
    logic          rd, hwr, lwr, hwr2, lwr2;
    logic [DW-1:0] d1, d2, rdat;
    logic          exp_start;
    logic [AW:1]   exp_addr;
    logic [DW-1:0] exp_data;
    int            exp_rclk, exp_we, exp_oe, exp_bhe, exp_ble;
    logic [DW-1:0] exp_dout;
  } vec_t;

  pin_t          exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [AW:1]   m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_dout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pin_t sample();
    pin_t p;
    p.busy     = bus.busy;
    p.ready    = bus.ready;
    p.we_n     = bus._we;
    p.oe_n     = bus._oe;
    p.bhe_n    = bus._bhe;
    p.ble_n    = bus._ble;
    p.data_oe  = bus.data_oe;
    p.address  = bus.address;
    p.data     = bus.data;
    p.data_out = bus.data_out;
    return p;
  endfunction

  function automatic pin_t mk_pin(input logic busy, input logic ready, input logic we_n,
                                  input logic oe_n, input logic bhe_n, input logic ble_n,
                                  input logic doe, input logic [AW:1] a,
                                  input logic [DW-1:0] d, input logic [DW-1:0] dout);
    pin_t p;
    p.busy = busy; p.ready = ready; p.we_n = we_n; p.oe_n = oe_n;
    p.bhe_n = bhe_n; p.ble_n = ble_n; p.data_oe = doe;
    p.address = a; p.data = d; p.data_out = dout;
    return p;
  endfunction

  // Bank mapping written straight from the memory map rules.
  function automatic logic [AW:1] ref_map(input logic [7:0] b, input logic [23:1] a);
    logic [AW:1] m;
    logic [4:0]  hi;
    if (b[7] || b[6])  hi = {3'b111, b[7], a[18]};
    else if (b[5])     hi = {2'b00, b[3] || b[2], b[3] || b[1], a[18]};
    else               hi = a[22:18];
    m = '0;
    m[17:1]  = a[17:1];
    m[22:18] = hi;
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.c1 = 1'b0; bus.c3 = 1'b0; bus.bank = 8'h00; bus.address_in = '0;
    bus.rd = 1'b0; bus.hwr = 1'b0; bus.lwr = 1'b0; bus.hwr2 = 1'b0; bus.lwr2 = 1'b0;
    bus.data_in = '0; bus.data_in2 = '0;
  endtask

  task automatic noise();
    bus.c1 = 1'($urandom); bus.c3 = 1'($urandom); bus.bank = 8'($urandom);
    bus.address_in = 23'($urandom);
    bus.rd = 1'($urandom); bus.hwr = 1'($urandom); bus.lwr = 1'($urandom);
    bus.hwr2 = 1'($urandom); bus.lwr2 = 1'($urandom);
    bus.data_in = DW'($urandom); bus.data_in2 = DW'($urandom);
  endtask

  task automatic drive_req(input logic [7:0] b, input logic [23:1] a, input logic r,
                           input logic h, input logic l, input logic h2, input logic l2,
                           input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    bus.c1 = 1'b1; bus.c3 = 1'b0; bus.bank = b; bus.address_in = a;
    bus.rd = r; bus.hwr = h; bus.lwr = l; bus.hwr2 = h2; bus.lwr2 = l2;
    bus.data_in = d1; bus.data_in2 = d2;
  endtask

  // Table vector: observe a fixed 11-clock window and count strobe activity.
  task automatic run_vec(input vec_t v, input int idx);
    int rclk, rcnt, we_c, oe_c, bhe_c, ble_c;
    logic [AW:1]   a1;
    logic [DW-1:0] d1s;
    logic          b1;
    rclk = 0; rcnt = 0; we_c = 0; oe_c = 0; bhe_c = 0; ble_c = 0;
    a1 = '0; d1s = '0; b1 = 1'b0;
    drive_req(v.bank, v.addr, v.rd, v.hwr, v.lwr, v.hwr2, v.lwr2, v.d1, v.d2);
    bus.ramdata_in = v.rdat;
    tick();
    quiet();
    for (int c = 1; c <= 11; c++) begin
      if (c == 1) begin a1 = bus.address; d1s = bus.data; b1 = bus.busy; end
      if (bus.ready) begin rcnt++; rclk = c; end
      if (!bus._we)  we_c++;
      if (!bus._oe)  oe_c++;
      if (!bus._bhe) bhe_c++;
      if (!bus._ble) ble_c++;
      tick();
    end
    check($sformatf("vec%0d start", idx), 64'(b1), 64'(v.exp_start));
    if (v.exp_start) begin
      check($sformatf("vec%0d address", idx), 64'(a1), 64'(v.exp_addr));
      check($sformatf("vec%0d data", idx), 64'(d1s), 64'(v.exp_data));
    end
    check($sformatf("vec%0d ready_clk", idx), 64'(rclk), 64'(v.exp_rclk));
    check($sformatf("vec%0d ready_cnt", idx), 64'(rcnt), 64'(v.exp_start ? 1 : 0));
    check($sformatf("vec%0d we_clks", idx), 64'(we_c), 64'(v.exp_we));
    check($sformatf("vec%0d oe_clks", idx), 64'(oe_c), 64'(v.exp_oe));
    check($sformatf("vec%0d bhe_clks", idx), 64'(bhe_c), 64'(v.exp_bhe));
    check($sformatf("vec%0d ble_clks", idx), 64'(ble_c), 64'(v.exp_ble));
    check($sformatf("vec%0d data_out", idx), 64'(bus.data_out), 64'(v.exp_dout));
  endtask

  // Random cycle: model builds the expected pin trace as a list of words,
  // each word being setup, L strobe clocks and hold, followed by one idle clock.
  task automatic run_random(input int t);
    logic [7:0]    b;
    logic [23:1]   a;
    logic          r, h, l, h2, l2, c1, c3, st;
    logic [DW-1:0] d1, d2;
    logic [DW-1:0] rdat [0:15];
    logic [AW:1]   wa [0:1];
    logic [DW-1:0] wd [0:1];
    logic          wh [0:1];
    logic          wl [0:1];
    int            nw, k, len;
    b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
    a  = 23'($urandom);
    r  = ($urandom_range(0, 3) == 0);
    h  = 1'($urandom); l = 1'($urandom); h2 = 1'($urandom); l2 = 1'($urandom);
    d1 = DW'($urandom); d2 = DW'($urandom);
    if ($urandom_range(0, 7) != 0) begin c1 = 1'b1; c3 = 1'b0; end
    else begin c1 = 1'($urandom); c3 = c1 ? 1'b1 : 1'($urandom); end
    for (int i = 0; i < 16; i++) rdat[i] = DW'($urandom);

    st = c1 && !c3 && (b != 8'h00) && (r || h || l || ((BURST2 != 0) && (h2 || l2)));
    nw = 0;
    if (st) begin
      if (r) begin
        wa[0] = ref_map(b, a); wd[0] = d1; wh[0] = 1'b1; wl[0] = 1'b1; nw = 1;
      end else begin
        if (h || l) begin
          wa[nw] = ref_map(b, a); wd[nw] = d1; wh[nw] = h; wl[nw] = l; nw++;
        end
        if ((BURST2 != 0) && (h2 || l2)) begin
          wa[nw] = ref_map(b, a) + AW'(1); wd[nw] = d2; wh[nw] = h2; wl[nw] = l2; nw++;
        end
      end
    end
    len = r ? RD_WAIT + 1 : WR_WAIT + 1;
    k = 0;
    for (int w = 0; w < nw; w++) begin
      k++;
      exp_q.push_back(mk_pin(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, !r, wa[w], wd[w], m_dout));
      for (int s = 0; s < len; s++) begin
        k++;
        exp_q.push_back(mk_pin(1'b1, 1'b0, r, !r, r ? 1'b0 : !wh[w], r ? 1'b0 : !wl[w],
                               !r, wa[w], wd[w], m_dout));
      end
      if (r) m_dout = rdat[k];
      k++;
      exp_q.push_back(mk_pin(1'b1, (w == nw - 1), 1'b1, 1'b1, 1'b1, 1'b1, !r,
                             wa[w], wd[w], m_dout));
      m_addr = wa[w];
      m_data = wd[w];
    end
    exp_q.push_back(mk_pin(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, m_addr, m_data, m_dout));

    drive_req(b, a, r, h, l, h2, l2, d1, d2);
    bus.c1 = c1; bus.c3 = c3;
    bus.ramdata_in = rdat[0];
    tick();
    for (int c = 1; c <= 16 && exp_q.size() > 0; c++) begin
      pin_t e;
      pin_t s;
      e = exp_q.pop_front();
      s = sample();
      check($sformatf("rand%0d clk%0d pins", t, c), 64'(s), 64'(e));
      if (exp_q.size() > 0) begin
        noise();
        bus.ramdata_in = rdat[c];
        tick();
      end else begin
        quiet();
      end
    end
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl [0:8];
    int   rcnt, we_c, bsy;
    pin_t rst_exp;

    tbl[0] = '{8'h20, 23'h020000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA5C3,
               1'b1, 22'h020000, 16'h0000, 5, 0, 3, 3, 3, 16'hA5C3};
    tbl[1] = '{8'h01, 23'h012345, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 16'h0000,
               1'b1, 22'h012345, 16'hBEEF, 4, 2, 0, 2, 0, 16'hA5C3};
    tbl[2] = '{8'h01, 23'h7FFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'h0000,
               1'b1, 22'h3FFFFF, 16'h1111, 8, 4, 0, 4, 4, 16'hA5C3};
    tbl[3] = '{8'h80, 23'h020000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234,
               1'b1, 22'h3E0000, 16'h0000, 5, 0, 3, 3, 3, 16'h1234};
    tbl[4] = '{8'h24, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A,
               1'b1, 22'h0BFFFF, 16'h0000, 5, 0, 3, 3, 3, 16'h5A5A};
    tbl[5] = '{8'h00, 23'h000100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF,
               1'b0, 22'h000000, 16'h0000, 0, 0, 0, 0, 0, 16'h5A5A};
    tbl[6] = '{8'h01, 23'h000055, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F,
               1'b1, 22'h000055, 16'h0000, 5, 0, 3, 3, 3, 16'h0F0F};
    tbl[7] = '{8'h02, 23'h001000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h9999, 16'hCAFE, 16'h0000,
               1'b1, 22'h001001, 16'hCAFE, 4, 2, 0, 2, 0, 16'h0F0F};
    tbl[8] = '{8'h01, 23'h0000FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h0000, 16'h0000,
               1'b1, 22'h0000FF, 16'h7777, 4, 2, 0, 0, 2, 16'h0F0F};

    reset = 1'b1;
    quiet();
    bus.ramdata_in = '0;
    tick();
    tick();
    rst_exp = mk_pin(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0);
    check("reset pins", 64'(sample()), 64'(rst_exp));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Second Q1 request arriving mid-cycle must be ignored.
    drive_req(8'h01, 23'h000100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    bus.ramdata_in = 16'h3C3C;
    tick();
    rcnt = 0; we_c = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) drive_req(8'h01, 23'h000200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4444, 16'h0000);
      if (c == 5) quiet();
      if (bus.ready) rcnt++;
      if (!bus._we)  we_c++;
      tick();
    end
    check("busy ignore ready_cnt", 64'(rcnt), 64'(1));
    check("busy ignore we_clks", 64'(we_c), 64'(0));
    check("busy ignore data_out", 64'(bus.data_out), 64'(16'h3C3C));

    // Asynchronous reset in the middle of a write strobe.
    drive_req(8'h01, 23'h000200, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hAAAA, 16'hBBBB);
    tick();
    quiet();
    tick();
    check("pre-reset we low", 64'(bus._we), 64'(0));
    reset = 1'b1;
    #1;
    rst_exp = mk_pin(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0);
    check("mid-cycle reset pins", 64'(sample()), 64'(rst_exp));
    tick();
    reset = 1'b0;
    rcnt = 0; bsy = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.ready) rcnt++;
      if (bus.busy)  bsy++;
      tick();
    end
    check("post-reset ready_cnt", 64'(rcnt), 64'(0));
    check("post-reset busy_clks", 64'(bsy), 64'(0));

    m_addr = '0;
    m_data = '0;
    m_dout = '0;
    for (int t = 0; t < 80; t++) run_random(t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
